// File: rtl/param_stack.sv
// Descending LIFO stack with pointer load, combined push/pop and sticky error flags.
module param_stack #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter bit          WRAP_EN = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD,
    input  logic [ADDR_W-1:0] LD_VAL,
    input  logic              PUSH,
    input  logic [DATA_W-1:0] PUSH_DATA,
    input  logic              POP,
    input  logic              ERR_CLR,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic [ADDR_W:0]   COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic [DATA_W-1:0] POP_DATA,
    output logic              POP_VALID,
    output logic              ERR_OVF,
    output logic              ERR_UNF
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] sp_q, sp_n, sp_dec, sp_inc, waddr;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] pd_q, pd_n, wdata;
    logic              pv_q, pv_n;
    logic              ovf_q, ovf_n, unf_q, unf_n;
    logic              ovf_set, unf_set, we;
    logic              empty, full;

    assign empty  = (cnt_q == CNT_W'(0));
    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign sp_dec = sp_q - ADDR_W'(1);
    assign sp_inc = sp_q + ADDR_W'(1);

    // Request arbitration: LD > PUSH+POP > PUSH > POP.
    always_comb begin
        sp_n    = sp_q;
        cnt_n   = cnt_q;
        pd_n    = pd_q;
        pv_n    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        we      = 1'b0;
        waddr   = sp_q;
        wdata   = PUSH_DATA;
        if (LD) begin
            sp_n  = LD_VAL;
            cnt_n = {1'b0, ADDR_W'(0) - LD_VAL};
        end else if (PUSH && POP) begin
            pv_n = 1'b1;
            if (empty) begin
                pd_n = PUSH_DATA;
            end else begin
                pd_n  = mem[sp_q];
                we    = 1'b1;
                waddr = sp_q;
            end
        end else if (PUSH) begin
            if (full) begin
                ovf_set = 1'b1;
                if (WRAP_EN) begin
                    we    = 1'b1;
                    waddr = sp_dec;
                    sp_n  = sp_dec;
                end
            end else begin
                we    = 1'b1;
                waddr = sp_dec;
                sp_n  = sp_dec;
                cnt_n = cnt_q + CNT_W'(1);
            end
        end else if (POP) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                pd_n  = mem[sp_q];
                pv_n  = 1'b1;
                sp_n  = sp_inc;
                cnt_n = cnt_q - CNT_W'(1);
            end
        end
        ovf_n = (ovf_q && !ERR_CLR) || ovf_set;
        unf_n = (unf_q && !ERR_CLR) || unf_set;
    end

    // Control and output registers, asynchronously cleared.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_q  <= '0;
            cnt_q <= '0;
            pd_q  <= '0;
            pv_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_n;
            cnt_q <= cnt_n;
            pd_q  <= pd_n;
            pv_q  <= pv_n;
            ovf_q <= ovf_n;
            unf_q <= unf_n;
        end
    end

    // Storage array; contents survive reset, so no reset term here.
    always_ff @(posedge CLK) begin
        if (we && RST_N) begin
            mem[waddr] <= wdata;
        end
    end

    assign SP_OUT    = sp_q;
    assign COUNT     = cnt_q;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign POP_DATA  = pd_q;
    assign POP_VALID = pv_q;
    assign ERR_OVF   = ovf_q;
    assign ERR_UNF   = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: a reject-mode and a wrap-mode instance share stimulus.
module tb_param_stack;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              LD = 1'b0;
    logic [ADDR_W-1:0] LD_VAL = '0;
    logic              PUSH = 1'b0;
    logic [DATA_W-1:0] PUSH_DATA = '0;
    logic              POP = 1'b0;
    logic              ERR_CLR = 1'b0;

    logic [ADDR_W-1:0] sp0, sp1;
    logic [ADDR_W:0]   cnt0, cnt1;
    logic              emp0, emp1, ful0, ful1;
    logic [DATA_W-1:0] pd0, pd1;
    logic              pv0, pv1, ovf0, ovf1, unf0, unf1;

    int checks = 0;
    int errors = 0;

    param_stack #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP_EN(1'b0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .LD_VAL(LD_VAL), .PUSH(PUSH),
        .PUSH_DATA(PUSH_DATA), .POP(POP), .ERR_CLR(ERR_CLR), .SP_OUT(sp0),
        .COUNT(cnt0), .EMPTY(emp0), .FULL(ful0), .POP_DATA(pd0),
        .POP_VALID(pv0), .ERR_OVF(ovf0), .ERR_UNF(unf0)
    );

    param_stack #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP_EN(1'b1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .LD_VAL(LD_VAL), .PUSH(PUSH),
        .PUSH_DATA(PUSH_DATA), .POP(POP), .ERR_CLR(ERR_CLR), .SP_OUT(sp1),
        .COUNT(cnt1), .EMPTY(emp1), .FULL(ful1), .POP_DATA(pd1),
        .POP_VALID(pv1), .ERR_OVF(ovf1), .ERR_UNF(unf1)
    );

    always #5 CLK = ~CLK;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        PUSH = 1'b1; PUSH_DATA = d;
        cyc();
        PUSH = 1'b0;
    endtask

    task automatic do_pop();
        POP = 1'b1;
        cyc();
        POP = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sp0"},  32'(sp0),  32'h0);
        chk({tag, "_cnt0"}, 32'(cnt0), 32'h0);
        chk({tag, "_pd0"},  32'(pd0),  32'h0);
        chk({tag, "_pv0"},  32'(pv0),  32'h0);
        chk({tag, "_ovf0"}, 32'(ovf0), 32'h0);
        chk({tag, "_unf0"}, 32'(unf0), 32'h0);
        chk({tag, "_cnt1"}, 32'(cnt1), 32'h0);
        chk({tag, "_ovf1"}, 32'(ovf1), 32'h0);
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        #2;
        chk_reset_vals(tag);
        RST_N = 1'b1;
        cyc();
    endtask

    initial begin
        // Power-up reset
        #3;
        chk_reset_vals("por");
        #10;
        RST_N = 1'b1;
        cyc();
        chk("por_empty", 32'(emp0), 32'h1);

        // Basic push/pop ordering
        do_push(8'h11); chk("p1_sp", 32'(sp0), 32'h3);
        do_push(8'h22); chk("p2_sp", 32'(sp0), 32'h2);
        do_push(8'h33); chk("p3_sp", 32'(sp0), 32'h1);
        chk("p3_cnt", 32'(cnt0), 32'h3);
        do_pop(); chk("pop1_d", 32'(pd0), 32'h33); chk("pop1_v", 32'(pv0), 32'h1);
        cyc();    chk("pop1_vlo", 32'(pv0), 32'h0); chk("pop1_hold", 32'(pd0), 32'h33);
        do_pop(); chk("pop2_d", 32'(pd0), 32'h22); chk("pop2_v", 32'(pv0), 32'h1);
        cyc();    chk("pop2_vlo", 32'(pv0), 32'h0);
        do_pop(); chk("pop3_d", 32'(pd0), 32'h11); chk("pop3_v", 32'(pv0), 32'h1);
        chk("pop3_empty", 32'(emp0), 32'h1);
        chk("pop3_sp", 32'(sp0), 32'h0);

        // Full-stack behaviour, reject vs. wrap
        do_reset("rst2");
        for (int i = 0; i < 4; i++) do_push(8'hA0 + 8'(i));
        chk("full0", 32'(ful0), 32'h1);
        chk("full1", 32'(ful1), 32'h1);
        chk("full_ovf0_pre", 32'(ovf0), 32'h0);
        do_push(8'hA4);
        chk("ovf0", 32'(ovf0), 32'h1);
        chk("ovf1", 32'(ovf1), 32'h1);
        chk("ovf_cnt0", 32'(cnt0), 32'h4);
        chk("ovf_cnt1", 32'(cnt1), 32'h4);
        chk("ovf_sp0", 32'(sp0), 32'h0);
        chk("ovf_sp1", 32'(sp1), 32'h3);
        do_pop(); chk("rj_pop1", 32'(pd0), 32'hA3); chk("wr_pop1", 32'(pd1), 32'hA4);
        do_pop(); chk("rj_pop2", 32'(pd0), 32'hA2); chk("wr_pop2", 32'(pd1), 32'hA3);
        do_pop(); chk("rj_pop3", 32'(pd0), 32'hA1); chk("wr_pop3", 32'(pd1), 32'hA2);
        do_pop(); chk("rj_pop4", 32'(pd0), 32'hA0); chk("wr_pop4", 32'(pd1), 32'hA1);
        chk("drain_empty0", 32'(emp0), 32'h1);
        chk("drain_empty1", 32'(emp1), 32'h1);

        // Underflow and sticky clear
        ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
        chk("clr_ovf", 32'(ovf0), 32'h0);
        chk("clr_unf_pre", 32'(unf0), 32'h0);
        do_pop();
        chk("unf_pv", 32'(pv0), 32'h0);
        chk("unf_set", 32'(unf0), 32'h1);
        chk("unf_sp", 32'(sp0), 32'h0);
        ERR_CLR = 1'b1; POP = 1'b1; cyc(); ERR_CLR = 1'b0; POP = 1'b0;
        chk("unf_setwins", 32'(unf0), 32'h1);
        ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
        chk("unf_clr", 32'(unf0), 32'h0);

        // Simultaneous push/pop, load, load priority
        do_reset("rst3");
        PUSH = 1'b1; POP = 1'b1; PUSH_DATA = 8'h77; cyc(); PUSH = 1'b0; POP = 1'b0;
        chk("pp_empty_d", 32'(pd0), 32'h77);
        chk("pp_empty_v", 32'(pv0), 32'h1);
        chk("pp_empty_cnt", 32'(cnt0), 32'h0);
        chk("pp_empty_unf", 32'(unf0), 32'h0);
        do_push(8'h55);
        PUSH = 1'b1; POP = 1'b1; PUSH_DATA = 8'h66; cyc(); PUSH = 1'b0; POP = 1'b0;
        chk("pp_d", 32'(pd0), 32'h55);
        chk("pp_v", 32'(pv0), 32'h1);
        chk("pp_cnt", 32'(cnt0), 32'h1);
        chk("pp_sp", 32'(sp0), 32'h3);
        do_pop(); chk("pp_pop", 32'(pd0), 32'h66);
        LD = 1'b1; LD_VAL = 2'd1; cyc(); LD = 1'b0;
        chk("ld_sp", 32'(sp0), 32'h1);
        chk("ld_cnt", 32'(cnt0), 32'h3);
        chk("ld_pv", 32'(pv0), 32'h0);
        chk("ld_pd", 32'(pd0), 32'h66);
        LD = 1'b1; LD_VAL = 2'd2; PUSH = 1'b1; PUSH_DATA = 8'h99; cyc();
        LD = 1'b0; PUSH = 1'b0;
        chk("ldp_sp", 32'(sp0), 32'h2);
        chk("ldp_cnt", 32'(cnt0), 32'h2);
        do_pop(); chk("ldp_mem", 32'(pd0), 32'hA1);
        chk("ldp_sp2", 32'(sp0), 32'h3);

        // Asynchronous reset in the middle of a push burst
        do_reset("rst4");
        do_push(8'h01);
        do_push(8'h02);
        PUSH = 1'b1; PUSH_DATA = 8'h03;
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_vals("midrst");
        RST_N = 1'b1;
        cyc();
        PUSH = 1'b0;
        chk("post_rst_sp", 32'(sp0), 32'h3);
        chk("post_rst_cnt", 32'(cnt0), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter DATA_W, default 8, entry width in bits.
REQ-002 Parameter ADDR_W, default 8, pointer width; depth DEPTH = 2^ADDR_W entries.
REQ-003 Parameter WRAP_EN, default 0, full-stack push policy: 0 = reject, 1 = overwrite oldest.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 LD  input  1  load stack pointer from LD_VAL.
REQ-007 LD_VAL  input  ADDR_W  value loaded into SP_OUT.
REQ-008 PUSH  input  1  push PUSH_DATA.
REQ-009 PUSH_DATA  input  DATA_W  data to push.
REQ-010 POP  input  1  pop top entry.
REQ-011 ERR_CLR  input  1  clear sticky error flags.
REQ-012 SP_OUT  output  ADDR_W  current stack pointer; address of top entry.
REQ-013 COUNT  output  ADDR_W+1  number of valid entries, 0..DEPTH.
REQ-014 EMPTY  output  1  COUNT == 0, combinational from COUNT.
REQ-015 FULL  output  1  COUNT == DEPTH, combinational from COUNT.
REQ-016 POP_DATA  output  DATA_W  registered popped data.
REQ-017 POP_VALID  output  1  one-cycle pulse; POP_DATA valid this cycle.
REQ-018 ERR_OVF  output  1  sticky overflow flag.
REQ-019 ERR_UNF  output  1  sticky underflow flag.

Function
REQ-020 Stack SHALL be descending: storage is an internal DEPTH x DATA_W array; top entry at mem[SP_OUT].
REQ-021 Push SHALL write mem[SP_OUT-1] <= PUSH_DATA, set SP_OUT <= SP_OUT-1 and COUNT <= COUNT+1; address arithmetic is modulo DEPTH.
REQ-022 Pop SHALL set POP_DATA <= mem[SP_OUT], SP_OUT <= SP_OUT+1, COUNT <= COUNT-1, and assert POP_VALID in the following cycle only; latency is one clock.
REQ-023 Priority SHALL be LD > (PUSH and POP) > PUSH > POP; a lower-priority request in the same cycle is discarded without error.
REQ-024 LD SHALL set SP_OUT <= LD_VAL and COUNT <= (DEPTH - LD_VAL) mod DEPTH; memory and POP_DATA are unchanged and POP_VALID is 0.
REQ-025 PUSH and POP together, not empty: POP_DATA <= mem[SP_OUT], mem[SP_OUT] <= PUSH_DATA, POP_VALID pulses, SP_OUT and COUNT unchanged.
REQ-026 PUSH and POP together, empty: POP_DATA <= PUSH_DATA, POP_VALID pulses, memory, SP_OUT and COUNT unchanged, no error.
REQ-027 PUSH alone when FULL, WRAP_EN=0: request ignored, ERR_OVF set.
REQ-028 PUSH alone when FULL, WRAP_EN=1: push performed as REQ-021, overwriting the oldest entry; COUNT held at DEPTH; ERR_OVF set.
REQ-029 POP alone when EMPTY: no state change, POP_VALID stays 0, ERR_UNF set (both modes).
REQ-030 ERR_OVF/ERR_UNF SHALL remain set until ERR_CLR; a set event in the same cycle as ERR_CLR wins.
REQ-031 POP_DATA SHALL hold its last value until the next successful pop.

Reset
REQ-032 RST_N low SHALL immediately force SP_OUT=0, COUNT=0, POP_DATA=0, POP_VALID=0, ERR_OVF=0, ERR_UNF=0, regardless of CLK.
REQ-033 Memory contents SHALL NOT be reset; reset mid-operation discards any in-flight push or pop.
REQ-034 Release of RST_N SHALL be followed by normal operation on the first subsequent rising edge.

Verification (ADDR_W=2, DATA_W=8)
REQ-035 Reset, push 0x11,0x22,0x33 -> SP_OUT 3,2,1; COUNT 3; pop x3 -> POP_DATA 0x33,0x22,0x11, each with a one-cycle POP_VALID pulse; EMPTY=1, SP_OUT=0.
REQ-036 WRAP_EN=0, push 5 values 0xA0..0xA4 -> FULL after the 4th push; 5th ignored, ERR_OVF=1; pops return 0xA3,0xA2,0xA1,0xA0.
REQ-037 WRAP_EN=1, same stimulus -> COUNT stays 4, ERR_OVF=1; first pop returns 0xA4, 4th pop returns 0xA1.
REQ-038 Pop when empty -> POP_VALID=0, ERR_UNF=1; ERR_CLR and new underflow in the same cycle -> ERR_UNF stays 1; ERR_CLR alone -> 0.
REQ-039 Push 0x55, then PUSH+POP with 0x66 -> POP_DATA=0x55, COUNT=1; pop -> 0x66; LD with LD_VAL=1 -> SP_OUT=1, COUNT=3; simultaneous LD+PUSH -> only the load takes effect.
REQ-040 Assert RST_N low between clock edges during a push burst -> all outputs return to reset values before the next edge.
